// File: rtl/l1_fill_arbiter.sv
// Miss/fill controller for the L1 block cache: round-robin arbitration over lane misses,
// one outstanding backing-store fetch, and a merged fill broadcast with timeout abort.
module l1_fill_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned POS_W   = 16,
    parameter int unsigned TYPE_W  = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [N_REQ-1:0]         req_valid_in,
    input  logic [N_REQ*POS_W-1:0]   req_pos_in,
    output logic [N_REQ-1:0]         fill_valid_out,
    output logic [POS_W-1:0]         fill_pos_out,
    output logic [TYPE_W-1:0]        fill_type_out,
    output logic                     fill_err_out,
    output logic                     mem_req_valid_out,
    input  logic                     mem_req_ready_in,
    output logic [POS_W-1:0]         mem_req_pos_out,
    input  logic                     mem_rsp_valid_in,
    input  logic [TYPE_W-1:0]        mem_rsp_type_in,
    output logic                     busy_out
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [PtrW-1:0] LastLane = PtrW'(N_REQ - 1);
    localparam logic [CntW-1:0] LastCnt  = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q;
    logic [PtrW-1:0]   rr_q;
    logic [PtrW-1:0]   gnt_q;
    logic [POS_W-1:0]  pos_q;
    logic [CntW-1:0]   cnt_q;

    logic              gnt_found;
    logic [PtrW-1:0]   gnt_idx;
    int unsigned       lane;
    logic [POS_W-1:0]  gnt_pos;
    logic [N_REQ-1:0]  hit;
    logic [PtrW-1:0]   rr_next;

    // First pending lane at or above the round-robin pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        lane      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            lane = (32'(rr_q) + i) % N_REQ;
            if (!gnt_found && req_valid_in[lane]) begin
                gnt_found = 1'b1;
                gnt_idx   = PtrW'(lane);
            end
        end
    end

    assign gnt_pos = req_pos_in[gnt_idx*POS_W +: POS_W];

    // Every lane still waiting on the fetched position shares this fill.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            hit[i] = req_valid_in[i] && (req_pos_in[i*POS_W +: POS_W] == pos_q);
        end
    end

    assign rr_next  = (gnt_q == LastLane) ? '0 : gnt_q + 1'b1;
    assign busy_out = (state_q != StIdle);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q           <= StIdle;
            rr_q              <= '0;
            gnt_q             <= '0;
            pos_q             <= '0;
            cnt_q             <= '0;
            fill_valid_out    <= '0;
            fill_pos_out      <= '0;
            fill_type_out     <= '0;
            fill_err_out      <= 1'b0;
            mem_req_valid_out <= 1'b0;
            mem_req_pos_out   <= '0;
        end else begin
            fill_valid_out <= '0;
            fill_pos_out   <= '0;
            fill_type_out  <= '0;
            fill_err_out   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        gnt_q             <= gnt_idx;
                        pos_q             <= gnt_pos;
                        mem_req_valid_out <= 1'b1;
                        mem_req_pos_out   <= gnt_pos;
                        state_q           <= StIssue;
                    end
                end
                StIssue: begin
                    if (mem_req_ready_in) begin
                        mem_req_valid_out <= 1'b0;
                        mem_req_pos_out   <= '0;
                        cnt_q             <= '0;
                        state_q           <= StWait;
                    end
                end
                StWait: begin
                    // A response in the final cycle beats the timeout.
                    if (mem_rsp_valid_in || (cnt_q == LastCnt)) begin
                        fill_valid_out <= hit;
                        fill_pos_out   <= pos_q;
                        fill_type_out  <= mem_rsp_valid_in ? mem_rsp_type_in : '0;
                        fill_err_out   <= !mem_rsp_valid_in;
                        state_q        <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    rr_q    <= rr_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_fill_arbiter.sv
// Directed and randomized bench for l1_fill_arbiter against a transaction-level reference model.
module tb_l1_fill_arbiter;

    localparam int N   = 4;
    localparam int T   = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_valid_in;
    logic [63:0] req_pos_in;
    logic [3:0]  fill_valid_out;
    logic [15:0] fill_pos_out;
    logic [7:0]  fill_type_out;
    logic        fill_err_out;
    logic        mem_req_valid_out;
    logic        mem_req_ready_in;
    logic [15:0] mem_req_pos_out;
    logic        mem_rsp_valid_in;
    logic [7:0]  mem_rsp_type_in;
    logic        busy_out;

    logic [15:0] lane_pos [4];
    assign req_pos_in = {lane_pos[3], lane_pos[2], lane_pos[1], lane_pos[0]};

    l1_fill_arbiter #(
        .N_REQ  (4),
        .POS_W  (16),
        .TYPE_W (8),
        .TIMEOUT(T)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_pos_in       (req_pos_in),
        .fill_valid_out   (fill_valid_out),
        .fill_pos_out     (fill_pos_out),
        .fill_type_out    (fill_type_out),
        .fill_err_out     (fill_err_out),
        .mem_req_valid_out(mem_req_valid_out),
        .mem_req_ready_in (mem_req_ready_in),
        .mem_req_pos_out  (mem_req_pos_out),
        .mem_rsp_valid_in (mem_rsp_valid_in),
        .mem_rsp_type_in  (mem_rsp_type_in),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: one open fetch described by its phase flags and elapsed wait.
    bit          m_open, m_asking, m_waiting, m_fill_evt;
    int          m_waited, m_gnt, m_rr;
    logic [15:0] m_pos;
    logic [3:0]  e_fv;
    logic [15:0] e_fpos, e_mpos;
    logic [7:0]  e_ftype;
    logic        e_ferr, e_mv, e_busy;

    // Stimulus controls.
    int          rdy_mode = 0;
    int          rsp_lat = 0;
    bit          rsp_rand = 0;
    bit          rand_req = 0;
    int          rsp_cnt = 0;
    logic [7:0]  fixed_type = 8'h00;
    logic [15:0] accepted [$];
    logic [12:0] fill_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_asking = 0; m_waiting = 0; m_fill_evt = 0;
        m_waited = 0; m_gnt = 0; m_rr = 0; m_pos = '0;
        e_fv = '0; e_fpos = '0; e_ftype = '0; e_ferr = 0; e_mv = 0; e_mpos = '0; e_busy = 0;
    endtask

    // Predict the outputs that follow the next clock edge from the inputs now applied.
    task automatic model_step();
        bit found;
        e_fv = '0; e_fpos = '0; e_ftype = '0; e_ferr = 0; m_fill_evt = 0;
        if (!m_open) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int l;
                l = (m_rr + k) % N;
                if (!found && req_valid_in[l]) begin
                    found = 1; m_open = 1; m_asking = 1; m_gnt = l; m_pos = lane_pos[l];
                end
            end
        end else if (m_asking) begin
            if (mem_req_ready_in) begin
                m_asking = 0; m_waiting = 1; m_waited = 0;
            end
        end else if (m_waiting) begin
            m_waited++;
            if (mem_rsp_valid_in || m_waited == T) begin
                for (int i = 0; i < N; i++) e_fv[i] = req_valid_in[i] && (lane_pos[i] == m_pos);
                e_fpos     = m_pos;
                e_ftype    = mem_rsp_valid_in ? mem_rsp_type_in : 8'h00;
                e_ferr     = !mem_rsp_valid_in;
                m_waiting  = 0;
                m_fill_evt = 1;
            end
        end else begin
            m_rr   = (m_gnt + 1) % N;
            m_open = 0;
        end
        e_mv   = m_open && m_asking;
        e_mpos = e_mv ? m_pos : 16'h0;
        e_busy = m_open;
    endtask

    task automatic check_all();
        check("fill_valid", 64'(fill_valid_out), 64'(e_fv));
        check("fill_pos", 64'(fill_pos_out), 64'(e_fpos));
        check("fill_type", 64'(fill_type_out), 64'(e_ftype));
        check("fill_err", 64'(fill_err_out), 64'(e_ferr));
        check("mem_req_valid", 64'(mem_req_valid_out), 64'(e_mv));
        check("mem_req_pos", 64'(mem_req_pos_out), 64'(e_mpos));
        check("busy", 64'(busy_out), 64'(e_busy));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        check_all();
        if (m_fill_evt) fill_log.push_back({fill_valid_out, fill_type_out, fill_err_out});
        for (int i = 0; i < N; i++) if (e_fv[i]) req_valid_in[i] = 1'b0;
    endtask

    task automatic run(input int n);
        bit acc;
        logic [15:0] apos;
        for (int c = 0; c < n; c++) begin
            mem_req_ready_in = (rdy_mode == 0) ? 1'b1 :
                               (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rsp_valid_in = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rsp_valid_in = 1'b1;
                    mem_rsp_type_in  = rsp_rand ? 8'($urandom) : fixed_type;
                end
            end
            if (rand_req) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid_in[i] && $urandom_range(0, 3) == 0) begin
                        lane_pos[i]     = 16'h0100 + 16'($urandom_range(0, 3));
                        req_valid_in[i] = 1'b1;
                    end
                end
            end
            acc  = mem_req_valid_out && mem_req_ready_in;
            apos = mem_req_pos_out;
            tick();
            if (acc) begin
                accepted.push_back(apos);
                if (rsp_rand) rsp_cnt = $urandom_range(1, 20);
                else if (rsp_lat > 0) rsp_cnt = rsp_lat;
            end
        end
        mem_rsp_valid_in = 1'b0;
    endtask

    task automatic clear_logs();
        accepted.delete();
        fill_log.delete();
    endtask

    initial begin
        rst_in = 1'b0;
        req_valid_in = '0;
        for (int i = 0; i < N; i++) lane_pos[i] = '0;
        mem_req_ready_in = 1'b0;
        mem_rsp_valid_in = 1'b0;
        mem_rsp_type_in  = '0;
        model_reset();

        // Reset state, no clock edge required.
        #1;
        check_all();
        #21 rst_in = 1'b1;
        run(3);

        // All four lanes miss together; pointer starts at 0.
        for (int i = 0; i < N; i++) lane_pos[i] = 16'h0010 + 16'(i);
        req_valid_in = 4'hF; rsp_lat = 3; fixed_type = 8'h33;
        clear_logs();
        run(30);
        check("t3_count", 64'(accepted.size()), 64'd4);
        check("t3_ord0", 64'(accepted[0]), 64'h10);
        check("t3_ord1", 64'(accepted[1]), 64'h11);
        check("t3_ord2", 64'(accepted[2]), 64'h12);
        check("t3_ord3", 64'(accepted[3]), 64'h13);

        req_valid_in = 4'b1011;
        clear_logs();
        run(25);
        check("t3b_count", 64'(accepted.size()), 64'd3);
        check("t3b_ord0", 64'(accepted[0]), 64'h10);
        check("t3b_ord1", 64'(accepted[1]), 64'h11);
        check("t3b_ord2", 64'(accepted[2]), 64'h13);

        // Lane 0, dead backing store: timeout abort, late response ignored.
        lane_pos[0] = 16'h0050; req_valid_in = 4'b0001; rsp_lat = 0;
        clear_logs();
        run(24);
        check("t5_fill", 64'(fill_log[0]), 64'({4'b0001, 8'h00, 1'b1}));
        rsp_cnt = 1;
        run(3);
        check("t5_late", 64'(fill_log.size()), 64'd1);

        // Merge of two lanes on one position, pointer at 1.
        lane_pos[1] = 16'h00AA; lane_pos[3] = 16'h00AA; lane_pos[2] = 16'h00BB;
        req_valid_in = 4'b1110; rsp_lat = 2; fixed_type = 8'h5A;
        clear_logs();
        run(20);
        check("t4_count", 64'(accepted.size()), 64'd2);
        check("t4_first", 64'(accepted[0]), 64'hAA);
        check("t4_second", 64'(accepted[1]), 64'hBB);
        check("t4_fill0", 64'(fill_log[0]), 64'({4'b1010, 8'h5A, 1'b0}));
        check("t4_fill1", 64'(fill_log[1]), 64'({4'b0100, 8'h5A, 1'b0}));

        // Single lane-2 miss with a 3-cycle response.
        lane_pos[2] = 16'h1234; req_valid_in = 4'b0100; rsp_lat = 3; fixed_type = 8'h05;
        clear_logs();
        run(10);
        check("t2_count", 64'(fill_log.size()), 64'd1);
        check("t2_fill", 64'(fill_log[0]), 64'({4'b0100, 8'h05, 1'b0}));

        // Stalled request channel, then the lane abandons its miss mid-wait.
        lane_pos[0] = 16'h0066; req_valid_in = 4'b0001; rdy_mode = 2;
        clear_logs();
        run(52);
        check("t6_hold_valid", 64'(mem_req_valid_out), 64'd1);
        check("t6_hold_pos", 64'(mem_req_pos_out), 64'h66);
        rdy_mode = 0;
        run(1);
        req_valid_in[0] = 1'b0;
        run(8);
        check("t6_fill", 64'(fill_log[0]), 64'({4'b0000, 8'h05, 1'b0}));
        check("t6_idle", 64'(busy_out), 64'd0);

        // Asynchronous reset in the middle of a wait.
        lane_pos[1] = 16'h0077; req_valid_in = 4'b0010; rsp_lat = 0;
        clear_logs();
        run(4);
        #2 rst_in = 1'b0;
        #1;
        model_reset();
        check_all();
        req_valid_in = '0;
        @(negedge clk_in);
        rst_in = 1'b1;
        rsp_cnt = 1;
        run(3);
        check("rst_no_fill", 64'(fill_log.size()), 64'd0);

        // Randomized traffic with contention, merges and occasional timeouts.
        rand_req = 1; rdy_mode = 1; rsp_rand = 1;
        run(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l1_fill_arbiter.md
Name: l1_fill_arbiter

Overview:
Miss/fill controller for the 4-port L1 block cache. Each cache lane raises a miss for a BlockPos. The block round-robin arbitrates among the lanes and issues one outstanding fetch at a time to the backing world store over a valid/ready request channel. When the response arrives, it broadcasts the BlockType fill to every lane still waiting on the same position. A timeout guards against a dead backing store.

Parameters:
N_REQ, 4, number of requesting cache lanes
POS_W, 16, width of BlockPos
TYPE_W, 8, width of BlockType
TIMEOUT, 256, max cycles in WAIT before the fetch is aborted (≥2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
req_valid_in  input  N_REQ  per-lane miss pending; held with pos stable until that lane's fill
req_pos_in  input  N_REQ*POS_W  per-lane miss position, lane i at bits [i*POS_W +: POS_W]
fill_valid_out  output  N_REQ  one-cycle per-lane fill strobe (may be multi-hot)
fill_pos_out  output  POS_W  position being filled
fill_type_out  output  TYPE_W  fetched BlockType (0 on error)
fill_err_out  output  1  fill is a timeout abort
mem_req_valid_out  output  1  fetch request valid
mem_req_ready_in  input  1  backing store accepts request
mem_req_pos_out  output  POS_W  fetch position
mem_rsp_valid_in  input  1  fetch response valid (single cycle)
mem_rsp_type_in  input  TYPE_W  fetch response data
busy_out  output  1  state != IDLE

Behaviour:
- Reset (rst_in low, no clock needed): state=IDLE, rr pointer=0, timeout counter=0, all outputs 0. A response arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid_in bit is set, grant g = first set lane searching from rr pointer upward with wrap (N_REQ-1 -> 0). Latch g and req_pos_in[g] into pos_q, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_req_valid_out=1, mem_req_pos_out=pos_q (both registered, stable while waiting). On mem_req_ready_in=1, go to WAIT and clear the counter. Hold indefinitely while ready=0, with no timeout in ISSUE.
- WAIT: the counter increments each cycle.
  - If mem_rsp_valid_in=1, latch type and go to RESP with err=0.
  - Otherwise, if counter==TIMEOUT-1, go to RESP with err=1 and type=0.
  - If a response and the timeout coincide, the response wins.
- Merge rule: on the WAIT->RESP edge, register fill_valid_out[i] = req_valid_in[i] && req_pos_in[i]==pos_q for all i. If granted lane g dropped its request meanwhile, its bit is 0. A fill with no lane bits set is legal: the fetch is discarded.
- RESP: lasts exactly one cycle. fill_valid_out, fill_pos_out=pos_q, fill_type_out and fill_err_out are valid. rr pointer <= (g+1) mod N_REQ. Next state is IDLE. All fill outputs return to 0 the following cycle.
- Requester rule: after its fill strobe, a lane deasserts req_valid_in or presents a new position by the next cycle. A lane that keeps the same pos is treated as a new miss.
- mem_rsp_valid_in outside WAIT is ignored. mem_req_ready_in outside ISSUE is ignored.
- Latency, best case (ready immediate, response k cycles after acceptance): grant at cycle 0, request cycle 1, WAIT from cycle 2, fill strobe at cycle 2+k+1.
- Counter width: $clog2(TIMEOUT). Pointer width: $clog2(N_REQ).
- Only one fetch is in flight at a time. New misses during ISSUE/WAIT/RESP wait in place; they are not dropped.

Test Plan:
1. Assert then release rst_in with no requests -> all outputs 0, busy_out=0. Pull rst_in low mid-WAIT with no clock edge -> outputs clear immediately; a later mem_rsp_valid_in produces no fill.
2. Lane 2 requests 0x1234, ready immediate, response 0x05 three cycles later -> mem_req_pos_out=0x1234 for one cycle; fill_valid_out=4'b0100, fill_type_out=0x05, fill_err_out=0, strobe one cycle.
3. Lanes 0-3 request 0x0010..0x0013 simultaneously and hold each until filled -> fetch order 0,1,2,3. Then lanes 0,1,3 re-request (pointer=0) -> order 0,1,3.
4. Lanes 1 and 3 request 0x00AA, lane 2 requests 0x00BB, pointer=1 -> exactly one fetch of 0x00AA, fill_valid_out=4'b1010. Next fetch is 0x00BB with fill 4'b0100.
5. TIMEOUT=16, lane 0 requests, no response -> 16 cycles after acceptance: fill_valid_out=4'b0001, fill_err_out=1, fill_type_out=0. A response arriving later is ignored.
6. mem_req_ready_in held low for 50 cycles -> mem_req_valid_out and pos stay stable with no timeout. Lane 0 drops its request during WAIT -> response arrives but fill_valid_out=0, and the FSM returns to IDLE.
